// File: rtl/uart_tx_frame.sv
// UART frame serializer: start bit, LSB-first data, optional parity, stop bit.
// CLK runs at the baud rate, so every line bit lasts one cycle.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | line held at 1, waiting for DATA_VALID
// START  | start bit (0) on the line
// DATA   | data bit r_cnt on the line
// PARITY | parity bit on the line
// STOP   | stop bit (1) on the line, new byte may be taken
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CW-1:0]         r_cnt;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_tx;
  logic                  r_busy;

  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_par_bit;

  assign w_cnt_nxt = r_cnt + CW'(1);
  // Even parity is the plain XOR of the latched byte; odd parity inverts it.
  assign w_par_bit = (^r_data) ^ r_par_typ;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_cnt     <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (DATA_VALID) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_state   <= START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        START: begin
          r_state <= DATA;
          r_cnt   <= '0;
          r_tx    <= r_data[0];
        end
        DATA: begin
          if (r_cnt == LAST) begin
            if (r_par_en) begin
              r_state <= PARITY;
              r_tx    <= w_par_bit;
            end else begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
            r_tx  <= r_data[w_cnt_nxt];
          end
        end
        PARITY: begin
          r_state <= STOP;
          r_tx    <= 1'b1;
        end
        STOP: begin
          // Back-to-back: the next start bit follows the stop bit directly.
          if (DATA_VALID) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_state   <= START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = r_tx;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: constant frame table, directed corner
// sequences, then randomized traffic against a bit-queue line model.
module tb_uart_tx_frame;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       BUSY;

  int checks;
  int failures;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // exp holds the frame in time order, first line bit at exp[len-1]
  typedef struct packed {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic [10:0] exp;
    int          len;
  } vec_t;

  vec_t tbl [9];
  bit   q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge CLK);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
  endtask

  // Checks one frame bit per cycle; inputs are scrambled at k==2 and an
  // optional strobe is issued after the check at cycle st_at.
  task automatic frame_check(input string nm, input vec_t v, input int st_at,
                             input logic [7:0] sd, input logic spe, input logic spt);
    for (int k = 0; k < v.len; k++) begin
      @(negedge CLK);
      DATA_VALID = 1'b0;
      check($sformatf("%s_tx[%0d]", nm, k), 32'(TX_OUT), 32'(v.exp[v.len-1-k]));
      check($sformatf("%s_busy[%0d]", nm, k), 32'(BUSY), 32'd1);
      if (k == 2) begin
        P_DATA  = 8'h00;
        PAR_TYP = ~PAR_TYP;
        PAR_EN  = ~PAR_EN;
      end
      if (k == st_at) begin
        P_DATA     = sd;
        PAR_EN     = spe;
        PAR_TYP    = spt;
        DATA_VALID = 1'b1;
      end
    end
  endtask

  task automatic idle_check(input string nm);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    check({nm, "_tx"}, 32'(TX_OUT), 32'd1);
    check({nm, "_busy"}, 32'(BUSY), 32'd0);
  endtask

  task automatic model_push(input logic [7:0] d, input logic pe, input logic pt);
    int ones;
    ones = $countones(d);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pe) q.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
    q.push_back(1'b1);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 11'b0_0101001011, 10};
    tbl[1] = '{8'h07, 1'b1, 1'b0, 11'b01110000011, 11};
    tbl[2] = '{8'h07, 1'b1, 1'b1, 11'b01110000001, 11};
    tbl[3] = '{8'h81, 1'b1, 1'b0, 11'b01000000101, 11};
    tbl[4] = '{8'h3C, 1'b0, 1'b0, 11'b0_0001111001, 10};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 11'b01111111111, 11};
    tbl[6] = '{8'h00, 1'b1, 1'b0, 11'b00000000001, 11};
    tbl[7] = '{8'h55, 1'b0, 1'b0, 11'b0_0101010101, 10};
    tbl[8] = '{8'h0F, 1'b0, 1'b0, 11'b0_0111100001, 10};

    checks = 0;
    failures = 0;
    RST = 1'b0;
    P_DATA = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;

    // Reset held with the strobe toggling.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("rst_hold_tx", 32'(TX_OUT), 32'd1);
      check("rst_hold_busy", 32'(BUSY), 32'd0);
      DATA_VALID = ~DATA_VALID;
      P_DATA = 8'(i * 37);
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 3; i++) idle_check("rst_release");

    // Table-driven single frames (mid-frame input changes applied inside).
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].data, tbl[i].pe, tbl[i].pt);
      frame_check($sformatf("tbl%0d", i), tbl[i], -1, 8'h00, 1'b0, 1'b0);
      idle_check($sformatf("tbl%0d_end", i));
    end

    // Strobe during a data bit is dropped.
    send(8'h3C, 1'b0, 1'b0);
    frame_check("ignored", tbl[4], 4, 8'h00, 1'b1, 1'b0);
    idle_check("ignored_end");

    // Back-to-back: 0xFF odd parity strobed during the stop bit of 0x3C.
    send(8'h3C, 1'b0, 1'b0);
    frame_check("b2b_a", tbl[4], 9, 8'hFF, 1'b1, 1'b1);
    frame_check("b2b_b", tbl[5], -1, 8'h00, 1'b0, 1'b0);
    idle_check("b2b_end");

    // Reset during data bit 3 of 0x55, then a clean 0x0F frame.
    send(8'h55, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      DATA_VALID = 1'b0;
      check($sformatf("pre_rst_tx[%0d]", k), 32'(TX_OUT), 32'(tbl[7].exp[9-k]));
    end
    #2 RST = 1'b0;
    #1;
    check("mid_rst_tx", 32'(TX_OUT), 32'd1);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    idle_check("post_rst");
    send(8'h0F, 1'b0, 1'b0);
    frame_check("post_rst_0f", tbl[8], -1, 8'h00, 1'b0, 1'b0);
    idle_check("post_rst_0f_end");

    // Randomized traffic against the line model.
    q.delete();
    for (int c = 0; c < 1500; c++) begin
      logic       dv;
      logic [7:0] d;
      logic       pe;
      logic       pt;
      @(negedge CLK);
      if (q.size() > 0) begin
        check("rnd_tx", 32'(TX_OUT), 32'(q[0]));
        check("rnd_busy", 32'(BUSY), 32'd1);
        void'(q.pop_front());
      end else begin
        check("rnd_idle_tx", 32'(TX_OUT), 32'd1);
        check("rnd_idle_busy", 32'(BUSY), 32'd0);
      end
      dv = ($urandom_range(0, 2) == 0);
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      DATA_VALID = dv;
      if (dv && q.size() == 0) model_push(d, pe, pt);
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (12) @(negedge CLK);
    check("final_busy", 32'(BUSY), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmitter for the serial interface, the transmit-side counterpart of the receive path. It accepts a parallel byte with a one-cycle valid strobe and serializes it on `TX_OUT` as a frame: start bit, data LSB-first, optional parity bit, stop bit. `CLK` is the baud-rate clock, so each line bit lasts exactly one `CLK` cycle. `BUSY` tells the upstream producer when a new byte can be accepted.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame, must be ≥ 2.
- `CLK`  in  1  baud-rate clock; all logic on the rising edge.
- `RST`  in  1  reset; asynchronous, active-low.
- `P_DATA`  in  DATA_WIDTH  parallel byte; sampled only at the accepting edge.
- `DATA_VALID`  in  1  one-cycle strobe; `P_DATA` is valid.
- `PAR_EN`  in  1  1 means a parity bit is inserted; sampled with `P_DATA`.
- `PAR_TYP`  in  1  0 means even parity, 1 means odd parity; sampled with `P_DATA`.
- `TX_OUT`  out  1  serial line, registered; idle level is 1.
- `BUSY`  out  1  registered; 1 while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The state names the bit currently being driven on `TX_OUT`.
- Reset values: state IDLE, `TX_OUT`=1, `BUSY`=0, shift register 0, bit counter 0, latched parity configuration 0.
- IDLE:
  - `TX_OUT`=1, `BUSY`=0.
  - At an edge with `DATA_VALID`=1, the block latches `P_DATA`, `PAR_EN` and `PAR_TYP`, then moves to START with `TX_OUT`<=0 and `BUSY`<=1.
- START → DATA:
  - `TX_OUT`<=data[0] and the counter is set to 0.
- DATA:
  - At each edge the counter increments and `TX_OUT`<=data[counter+1].
  - After data[DATA_WIDTH-1] has been on the line for one cycle, the block moves to PARITY if the latched parity enable is 1, otherwise to STOP.
- PARITY:
  - `TX_OUT` is the XOR-reduction of the latched data when `PAR_TYP`=0 (even parity).
  - `TX_OUT` is the inverted XOR-reduction when `PAR_TYP`=1 (odd parity).
  - PARITY → STOP with `TX_OUT`<=1.
- STOP, `TX_OUT`=1, `BUSY`=1:
  - At the next edge, if `DATA_VALID`=1 the block latches new data and configuration and goes to START (`TX_OUT`<=0, `BUSY` stays 1). This is the back-to-back case, with no idle gap.
  - Otherwise the block goes to IDLE with `BUSY`<=0.
- `DATA_VALID` is ignored in START, DATA and PARITY. No error flag is raised and the byte is dropped.
- Changes on `P_DATA`, `PAR_EN` or `PAR_TYP` during a frame do not affect the frame in progress.
- The parity value is computed from the latched data, never from the live `P_DATA`.
- The counter is $clog2(DATA_WIDTH) bits wide and never wraps inside a frame.

## Timing
- Latency: the start bit appears on `TX_OUT` in the cycle right after the accepting edge.
- Frame length is DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity: 10 or 11 cycles at the default width.
- `BUSY` rises on the accepting edge and falls on the edge that ends the stop bit. `BUSY`=1 for exactly the frame length.
- In back-to-back operation `BUSY` stays 1 continuously, and the stop bit of frame n is immediately followed by the start bit of frame n+1.
- Both outputs come straight from flops, so there is no combinational path from inputs to outputs.
- Reset asserted mid-frame immediately forces `TX_OUT`=1 and `BUSY`=0 (asynchronous). After release the block is in IDLE and the partial frame is abandoned.
- The first `DATA_VALID` accepted after reset release is sampled at the first rising edge with `RST`=1.

## Test plan
- Reset check:
  - Hold `RST`=0 with `DATA_VALID` toggling. Required: `TX_OUT`=1 and `BUSY`=0 throughout.
  - Release reset with no strobe. Required: the line stays 1.
- No parity:
  - Stimulus: `P_DATA`=0xA5, `PAR_EN`=0.
  - Required `TX_OUT` per cycle: 0,1,0,1,0,0,1,0,1,1.
  - Required: `BUSY`=1 for exactly 10 cycles, then 0.
- Parity:
  - `P_DATA`=0x07, `PAR_EN`=1, `PAR_TYP`=0 (even). Required parity bit 1; frame 0,1,1,1,0,0,0,0,0,1,1; `BUSY` high for 11 cycles.
  - Repeat with `PAR_TYP`=1 (odd). Required parity bit 0.
- Back-to-back and ignored strobe:
  - Send 0x3C, then strobe 0xFF during the stop bit. Required: the stop bit is followed directly by a start bit and `BUSY` never drops.
  - Strobe 0x00 during a DATA cycle. Required: the strobe is ignored and the frame in progress is unchanged.
- Input change mid-frame:
  - Send 0x81 with even parity, then change `P_DATA` to 0x00 and `PAR_TYP` to 1 during DATA.
  - Required: the line carries 0x81 with parity bit 0.
- Reset mid-frame:
  - Assert `RST` during data bit 3 of 0x55. Required: `TX_OUT`=1 and `BUSY`=0 immediately.
  - After release, send 0x0F. Required: it is transmitted correctly.
